weighted_sum_sched: RTL
=======================

WEIGHTED_SUM_SCHED -- requirements
Module: weighted_sum_sched

Interface
REQ-001 Parameter: N_TERMS, 4, number of input terms accumulated per pass; legal range 1..4.
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst  input  1  reset, synchronous and active-high.
REQ-004 Port: start  input  1  request one accumulation pass; sampled only in IDLE.
REQ-005 Port: sign_mask  input  4  per-term sign; bit k = 1 subtracts term k, 0 adds it; latched on accepted start.
REQ-006 Port: sel  output  2  index of the term currently requested from the external value store.
REQ-007 Port: in_data  input  8  unsigned term value for index sel; combinational, same-cycle.
REQ-008 Port: in_valid  input  1  in_data valid this cycle; low stalls the scheduler.
REQ-009 Port: busy  output  1  high from the cycle after an accepted start until done is asserted.
REQ-010 Port: done  output  1  one-cycle pulse; result is updated in the same cycle.
REQ-011 Port: result  output  10  signed two's-complement saturated weighted sum; held between passes.

Function
REQ-012 Three states: IDLE, RUN and DONE.
REQ-013 IDLE->RUN when start=1 on edge T: clear idx to 0, clear acc to 0, latch sign_mask; busy=1 from T+1.
REQ-014 In RUN: sel=idx; in IDLE and DONE: sel=0.
REQ-015 Term scaling: term = (in_data>>1) + (in_data>>3), i.e. 0.625x truncated; 8-bit unsigned, max 158.
REQ-016 RUN with in_valid=1: acc <= acc - term if sign_mask[idx] = 1, else acc + term; then idx <= idx+1.
REQ-017 RUN with in_valid=0: acc and idx hold; no term is consumed.
REQ-018 acc is 12-bit signed with no intermediate saturation; the range ±632 is exact.
REQ-019 RUN->DONE on the valid cycle where idx = N_TERMS-1.
REQ-020 On entering DONE: result <= acc clamped to [-512, 511]; done=1 for exactly that cycle; busy=0.
REQ-021 DONE->IDLE unconditionally on the next edge; a start sampled while in DONE is ignored.
REQ-022 start in RUN is ignored; sign_mask changes after acceptance have no effect.
REQ-023 Latency with no stalls: start at edge T; RUN occupies T+1..T+N_TERMS; done at T+N_TERMS+1. Each stall cycle adds 1.
REQ-024 Back-to-back: a start held high re-accepts on the first IDLE cycle after DONE, giving a pass every N_TERMS+2 cycles.

Reset
REQ-025 rst=1 at an edge forces IDLE and sets idx=0, acc=0, result=0, done=0, busy=0 and sel=0, regardless of state.
REQ-026 Reset during RUN discards the partial sum; result stays 0 until a later pass completes.
REQ-027 rst has priority over start in the same cycle.

Verification
REQ-028 Inputs 48, 96, 146, 255 (sel 0..3), sign_mask=0001, in_valid=1, start at T -> done at T+5, result=279 (-30+60+91+158).
REQ-029 Same values with sign_mask=0000 -> result=339; with sign_mask=1111 -> result=-339.
REQ-030 All terms 255 with sign_mask=0000 -> result=511 (saturated from 632); with sign_mask=1111 -> result=-512.
REQ-031 Case of REQ-028 with in_valid low for 2 cycles while sel=2 -> sel holds at 2, done at T+7, result=279.
REQ-032 start pulsed during RUN -> no effect on sequence or result; rst during RUN at idx=2 -> next cycle IDLE, result=0, busy=0, no done pulse.
REQ-033 start held high across 2 passes of REQ-028 -> done pulses 6 cycles apart, both with result=279.

Source files
------------

// File: rtl/weighted_sum_sched.sv
// Sequential weighted-sum scheduler: reads N_TERMS values from an external store
// through sel/in_data, scales each by 0.625, adds or subtracts it, and saturates to 10 bits.
module weighted_sum_sched #(
    parameter int N_TERMS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [3:0]        sign_mask,
    output logic [1:0]        sel,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              busy,
    output logic              done,
    output logic signed [9:0] result
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [1:0] LAST = 2'(N_TERMS - 1);

    state_t             state_q, state_d;
    logic [1:0]         idx;
    logic [3:0]         mask;
    logic signed [11:0] acc;
    logic signed [11:0] acc_nxt;
    logic signed [11:0] term_ext;
    logic [7:0]         term;
    logic signed [9:0]  sat_val;
    logic               last_term;

    // 0.625x truncated; each shifted part is truncated separately
    assign term      = 8'(in_data >> 1) + 8'(in_data >> 3);
    assign term_ext  = $signed({4'b0000, term});
    assign acc_nxt   = mask[idx] ? (acc - term_ext) : (acc + term_ext);
    assign last_term = (idx == LAST);

    always_comb begin
        sat_val = acc_nxt[9:0];
        if (acc_nxt > 12'sd511)
            sat_val = 10'sd511;
        else if (acc_nxt < -12'sd512)
            sat_val = -10'sd512;
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        sel     = 2'd0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: if (start) state_d = RUN;
            RUN: begin
                sel  = idx;
                busy = 1'b1;
                if (in_valid && last_term) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx    <= 2'd0;
            acc    <= 12'sd0;
            mask   <= 4'd0;
            result <= 10'sd0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    idx  <= 2'd0;
                    acc  <= 12'sd0;
                    mask <= sign_mask;
                end
                RUN: if (in_valid) begin
                    acc <= acc_nxt;
                    idx <= idx + 2'd1;
                    if (last_term) result <= sat_val;
                end
                default: ;
            endcase
        end
    end

endmodule
